// File: rtl/pattern_trigger_pkg.sv
// Shared types and constants for the programmable start-shifting pattern trigger.
// The defaults reproduce the legacy fixed 1101 sticky detector.
package pattern_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } trig_state_t;

  localparam logic MODE_STICKY     = 1'b0;
  localparam logic MODE_CONTINUOUS = 1'b1;

  localparam int       DEFAULT_MAX_LEN = 8;
  localparam logic [7:0] DEFAULT_PAT_C = 8'b0000_1101;
  localparam int       DEFAULT_LEN_C   = 4;

endpackage

// File: rtl/pattern_window_cmp.sv
// Masked compare of the sampling window against the pattern; only the low
// i_len bits take part, higher pattern bits are don't-care.
module pattern_window_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] i_window,
  input  logic [MAX_LEN-1:0] i_pat,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_match
);

  logic [MAX_LEN-1:0] w_mask;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  assign o_match = (((i_window ^ i_pat) & w_mask) == '0);

endmodule

// File: rtl/pattern_timer_trigger_fsm.sv
// Programmable serial pattern detector driving start_shifting for the timer's
// shift/count stage. Sticky mode locks until ack; continuous mode pulses per match.
module pattern_timer_trigger_fsm
  import pattern_trigger_pkg::*;
#(
  parameter int               MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(DEFAULT_PAT_C),
  parameter int               DEFAULT_LEN = DEFAULT_LEN_C,
  localparam int              LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_value,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               mode,
  input  logic               ack,
  output logic               start_shifting,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  // The oldest history bit would only ever shift out, so it is not stored.
  trig_state_t          r_state, w_state_nxt;
  logic [MAX_LEN-2:0]   r_hist, w_hist_nxt;
  logic [LEN_W-1:0]     r_fill, w_fill_nxt;
  logic [MAX_LEN-1:0]   r_pat;
  logic [LEN_W-1:0]     r_len;
  logic                 r_mode;
  logic                 r_pulse, w_pulse_nxt;
  logic [CNT_W-1:0]     r_count;
  logic                 r_cfg_err;

  logic [MAX_LEN-1:0]   w_window;
  logic                 w_cmp;
  logic                 w_fill_ok;
  logic                 w_match;
  logic                 w_len_ok;

  assign w_window  = {r_hist, data};
  assign w_fill_ok = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len};
  assign w_match   = w_cmp & w_fill_ok;
  assign w_len_ok  = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));

  pattern_window_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .i_window (w_window),
    .i_pat    (r_pat),
    .i_len    (r_len),
    .o_match  (w_cmp)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_pulse_nxt = 1'b0;
    if (pat_load) begin
      // The bit on data during a load cycle is discarded.
      w_state_nxt = w_len_ok ? SEARCH : IDLE;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
    end else begin
      case (r_state)
        SEARCH: begin
          w_hist_nxt  = w_window[MAX_LEN-2:0];
          w_fill_nxt  = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
          w_pulse_nxt = w_match;
          if (w_match && (r_mode == MODE_STICKY)) begin
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (ack) begin
            w_state_nxt = SEARCH;
            w_hist_nxt  = '0;
            w_fill_nxt  = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= DEFAULT_PAT;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_mode    <= MODE_STICKY;
      r_pulse   <= 1'b0;
      r_count   <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_pulse <= w_pulse_nxt;
      if (pat_load) begin
        r_pat     <= pat_value;
        r_len     <= pat_len;
        r_mode    <= mode;
        r_cfg_err <= ~w_len_ok;
      end
      if (w_pulse_nxt && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign start_shifting = (r_mode == MODE_CONTINUOUS) ? r_pulse : (r_state == LOCKED);
  assign match_pulse    = r_pulse;
  assign match_count    = r_count;
  assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_pattern_timer_trigger_fsm.sv
// Bench for pattern_timer_trigger_fsm: a wide-counter instance and a CNT_W=2
// instance share stimulus and are checked against a bit-queue reference model.
module tb_pattern_timer_trigger_fsm;
  import pattern_trigger_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic               clk;
  logic               reset;
  logic               data;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_value;
  logic [LEN_W-1:0]   pat_len;
  logic               mode;
  logic               ack;

  logic               start_shifting, match_pulse, cfg_err;
  logic [7:0]         match_count;
  logic               start2, pulse2, cfg2;
  logic [1:0]         count2;

  pattern_timer_trigger_fsm #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .data           (data),
    .pat_load       (pat_load),
    .pat_value      (pat_value),
    .pat_len        (pat_len),
    .mode           (mode),
    .ack            (ack),
    .start_shifting (start_shifting),
    .match_pulse    (match_pulse),
    .match_count    (match_count),
    .cfg_err        (cfg_err)
  );

  pattern_timer_trigger_fsm #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut_sat (
    .clk            (clk),
    .reset          (reset),
    .data           (data),
    .pat_load       (pat_load),
    .pat_value      (pat_value),
    .pat_len        (pat_len),
    .mode           (mode),
    .ack            (ack),
    .start_shifting (start2),
    .match_pulse    (pulse2),
    .match_count    (count2),
    .cfg_err        (cfg2)
  );

  logic [15:0] dut_vec;
  assign dut_vec = {start_shifting, match_pulse, cfg_err, match_count, count2, start2, pulse2, cfg2};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_hist[$];
  logic [7:0] m_pat = DEFAULT_PAT_C;
  int         m_len = DEFAULT_LEN_C;
  logic       m_mode = 1'b0;
  logic       m_locked = 1'b0;
  logic       m_valid = 1'b1;
  logic       m_pulse = 1'b0;
  logic       m_cfg = 1'b0;
  int         m_count = 0;
  int         m_count_sat = 0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  function automatic bit model_match();
    int n;
    n = m_hist.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (m_hist[n - m_len + i] != int'(m_pat[m_len - 1 - i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] exp_vec();
    logic st;
    st = m_mode ? m_pulse : m_locked;
    return {st, m_pulse, m_cfg, 8'(m_count), 2'(m_count_sat), st, m_pulse, m_cfg};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pat = DEFAULT_PAT_C; m_len = DEFAULT_LEN_C; m_mode = 1'b0;
      m_locked = 1'b0; m_valid = 1'b1; m_pulse = 1'b0; m_cfg = 1'b0;
      m_count = 0; m_count_sat = 0; m_hist.delete();
    end else if (pat_load) begin
      m_pat = pat_value; m_len = int'(pat_len); m_mode = mode;
      m_hist.delete(); m_locked = 1'b0; m_pulse = 1'b0;
      m_valid = (m_len >= 1) && (m_len <= MAX_LEN);
      m_cfg = !m_valid;
    end else if (!m_valid) begin
      m_pulse = 1'b0;
    end else if (m_locked) begin
      m_pulse = 1'b0;
      if (ack) begin
        m_locked = 1'b0;
        m_hist.delete();
      end
    end else begin
      m_hist.push_back(int'(data));
      if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
      m_pulse = model_match();
      if (m_pulse) begin
        if (m_count < 255) m_count++;
        if (m_count_sat < 3) m_count_sat++;
        if (!m_mode) m_locked = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic send_bit(input logic b);
    data = b;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; pat_load = 1'b0; ack = 1'b0; data = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input int len, input logic md, input logic d);
    pat_load = 1'b1; pat_value = p; pat_len = LEN_W'(len); mode = md; data = d;
    tick();
    pat_load = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_vec !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_outputs cyc=%0d got=%h exp=%h", cyc, dut_vec, 16'h0000);
    end
  endtask

  task automatic test_legacy_default();
    logic [4:0] bits;
    do_reset();
    bits = 5'b01101;
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL legacy_seq cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if ({match_pulse, start_shifting, match_count} !== {1'b1, 1'b1, 8'd1}) begin
      n_errors++;
      $display("FAIL legacy_match cyc=%0d got=%b%b/%0d exp=11/1", cyc, match_pulse, start_shifting, match_count);
    end
    for (int i = 0; i < 20; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      n_checks++;
      if (start_shifting !== 1'b1 || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL legacy_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_sticky_ack();
    logic [3:0] pre;
    logic [3:0] relock;
    ack = 1'b1; data = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (start_shifting !== 1'b0 || match_pulse !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_release cyc=%0d got=%b%b exp=00", cyc, start_shifting, match_pulse);
    end
    // 1,0,1 would complete 1101 only if the pre-ack history survived.
    pre = 4'b0101;
    for (int i = 2; i >= 0; i--) begin
      send_bit(pre[i]);
      n_checks++;
      if (match_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL ack_no_old_hist cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    relock = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      send_bit(relock[i]);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL ack_relock_seq cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if ({match_pulse, start_shifting} !== 2'b11) begin
      n_errors++;
      $display("FAIL ack_relock cyc=%0d got=%b%b exp=11", cyc, match_pulse, start_shifting);
    end
  endtask

  task automatic test_continuous_overlap();
    logic [4:0] bits;
    logic [4:0] exp_p;
    int c0;
    load(8'b0000_0101, 3, MODE_CONTINUOUS, 1'b0);
    c0 = m_count;
    bits  = 5'b10101;
    exp_p = 5'b00101;
    for (int i = 4; i >= 0; i--) begin
      send_bit(bits[i]);
      n_checks++;
      if (match_pulse !== exp_p[i] || start_shifting !== exp_p[i] || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL cont_overlap cyc=%0d got=%b%b exp=%b", cyc, match_pulse, start_shifting, exp_p[i]);
      end
    end
    n_checks++;
    if (int'(match_count) !== c0 + 2) begin
      n_errors++;
      $display("FAIL cont_count got=%0d exp=%0d", match_count, c0 + 2);
    end
  endtask

  task automatic test_midstream_reload();
    logic [3:0] bits;
    load(8'b0000_1101, 4, MODE_STICKY, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    load(8'b0000_1101, 4, MODE_STICKY, 1'b1);
    n_checks++;
    if (match_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL reload_cycle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
    end
    bits = 4'b0101;
    for (int i = 2; i >= 0; i--) begin
      send_bit(bits[i]);
      n_checks++;
      if (match_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL reload_discard cyc=%0d got=%b exp=0", cyc, match_pulse);
      end
    end
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      n_checks++;
      if (match_pulse !== (i == 0) || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL reload_match cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_bad_config();
    int bad_len[2];
    logic [3:0] bits;
    bad_len[0] = 0;
    bad_len[1] = 9;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      load(8'hFF, bad_len[k], 1'($urandom_range(0, 1)), 1'b1);
      n_checks++;
      if ({cfg_err, start_shifting, match_pulse} !== 3'b100) begin
        n_errors++;
        $display("FAIL bad_cfg_flag len=%0d got=%b%b%b exp=100", bad_len[k], cfg_err, start_shifting, match_pulse);
      end
      for (int i = 0; i < 16; i++) begin
        ack = 1'($urandom_range(0, 1));
        send_bit(1'($urandom_range(0, 1)));
        n_checks++;
        if ({cfg_err, start_shifting, match_pulse, match_count} !== {3'b100, 8'd0} || dut_vec !== exp_vec()) begin
          n_errors++;
          $display("FAIL bad_cfg_idle cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
        end
      end
      ack = 1'b0;
    end
    load(8'b0000_1101, 4, MODE_STICKY, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_errors++;
      $display("FAIL bad_cfg_clear got=%b exp=0", cfg_err);
    end
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    n_checks++;
    if ({match_pulse, start_shifting} !== 2'b11 || dut_vec !== exp_vec()) begin
      n_errors++;
      $display("FAIL bad_cfg_recover cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    load(8'b0000_0001, 1, MODE_CONTINUOUS, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1);
      n_checks++;
      if (pulse2 !== 1'b1 || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL sat_pulse cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if (count2 !== 2'd3 || match_count !== 8'd6) begin
      n_errors++;
      $display("FAIL sat_hold got=%0d/%0d exp=3/6", count2, match_count);
    end
  endtask

  task automatic test_reset_collision();
    logic [3:0] bits;
    load(8'b0000_0011, 2, MODE_CONTINUOUS, 1'b0);
    send_bit(1'b1);
    reset = 1'b1; pat_load = 1'b1; pat_value = 8'b0000_0011; pat_len = 4'd2; mode = 1'b1; data = 1'b1;
    tick();
    reset = 1'b0; pat_load = 1'b0;
    n_checks++;
    if (dut_vec !== 16'h0000) begin
      n_errors++;
      $display("FAIL rst_collision cyc=%0d got=%h exp=%h", cyc, dut_vec, 16'h0000);
    end
    bits = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      send_bit(bits[i]);
      n_checks++;
      if (match_pulse !== (i == 0) || dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL rst_default_pat cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 79) == 0);
      pat_load  = ($urandom_range(0, 23) == 0);
      pat_value = 8'($urandom);
      pat_len   = 4'($urandom_range(0, 9));
      mode      = 1'($urandom_range(0, 1));
      ack       = ($urandom_range(0, 5) == 0);
      data      = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    reset = 1'b0; pat_load = 1'b0; ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data = 1'b0; pat_load = 1'b0; pat_value = '0;
    pat_len = '0; mode = 1'b0; ack = 1'b0;
    test_reset();
    test_legacy_default();
    test_sticky_ack();
    test_continuous_overlap();
    test_midstream_reload();
    test_bad_config();
    test_saturation();
    test_reset_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
